mem_port_arbiter: RTL and testbench

- Two-requester round-robin front end for the byte-wide, register-mapped async-SRAM/PSRAM controller.
- Each requester issues a 16-bit word read or write at a 23-bit address. The block arbitrates between them and runs the controller's register sequence: load address and data, issue command, poll status, fetch read data.
- It then returns a one-cycle ack to the winning requester.
- It sits between the PicoBlaze I/O decode plus a second master (e.g. display/DMA) and the memory controller's register port.

---
 rtl/mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin front end that sequences the byte-wide SRAM/PSRAM
// controller register port: load address/data, command, poll status, fetch read data.
module mem_port_arbiter #(
  parameter int unsigned POLL_TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req0,
  input  logic        i_we0,
  input  logic [22:0] i_addr0,
  input  logic [15:0] i_wdata0,
  output logic        o_ack0,
  input  logic        i_req1,
  input  logic        i_we1,
  input  logic [22:0] i_addr1,
  input  logic [15:0] i_wdata1,
  output logic        o_ack1,
  output logic [15:0] o_rdata,
  output logic        o_err,
  output logic        o_busy,
  output logic        o_mi_cs,
  output logic        o_mi_write,
  output logic        o_mi_read,
  output logic [3:0]  o_mi_address,
  output logic [7:0]  o_mi_data_in,
  input  logic [7:0]  i_mi_data_out
);

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] TO_LAST   = CW'(POLL_TIMEOUT - 1);
  localparam logic [3:0]    REG_RDLO  = 4'd6;
  localparam logic [3:0]    REG_RDHI  = 4'd7;
  localparam logic [3:0]    REG_START_RD = 4'd8;
  localparam logic [3:0]    REG_START_WR = 4'd9;
  localparam logic [3:0]    REG_STAT  = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE, S_PRECHK, S_LOAD, S_CMD, S_GAP, S_POLL, S_RDLO, S_RDHI, S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_k, w_k_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_grant, w_grant_nxt;
  logic          r_we, w_we_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [DW-1:0] r_wdata, w_wdata_nxt;
  logic [7:0]    r_rlo, w_rlo_nxt;
  logic [DW-1:0] r_rdata, w_rdata_nxt;
  logic          r_ack0, w_ack0_nxt;
  logic          r_ack1, w_ack1_nxt;
  logic          r_err, w_err_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_cs, w_cs_nxt;
  logic          r_wr, w_wr_nxt;
  logic          r_rd, w_rd_nxt;
  logic [3:0]    r_maddr, w_maddr_nxt;
  logic [7:0]    r_din, w_din_nxt;
  logic          w_win;

  // Contention goes to the requester that did not win last time.
  assign w_win = (i_req0 && i_req1) ? ~r_grant : i_req1;

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rlo_nxt   = r_rlo;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = 1'b0;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    w_cs_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    w_rd_nxt    = 1'b0;
    w_maddr_nxt = 4'd0;
    w_din_nxt   = 8'd0;

    unique case (r_state)
      S_IDLE: begin
        if (i_req0 || i_req1) begin
          w_grant_nxt = w_win;
          w_we_nxt    = w_win ? i_we1 : i_we0;
          w_addr_nxt  = w_win ? i_addr1 : i_addr0;
          w_wdata_nxt = w_win ? i_wdata1 : i_wdata0;
          w_state_nxt = S_PRECHK;
        end
      end
      S_PRECHK: begin
        if (i_mi_data_out[0]) begin
          w_state_nxt = S_LOAD;
          w_k_nxt     = 3'd0;
        end
      end
      S_LOAD: begin
        if (r_k == (r_we ? 3'd4 : 3'd2)) w_state_nxt = S_CMD;
        else                             w_k_nxt = r_k + 3'd1;
      end
      S_CMD: w_state_nxt = S_GAP;
      S_GAP: begin
        w_state_nxt = S_POLL;
        w_cnt_nxt   = '0;
      end
      S_POLL: begin
        if (i_mi_data_out[0]) begin
          w_state_nxt = r_we ? S_DONE : S_RDLO;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RDLO: begin
        w_rlo_nxt   = i_mi_data_out;
        w_state_nxt = S_RDHI;
      end
      // rdata changes only together with the ack so it stays stable between acks.
      S_RDHI: begin
        w_rdata_nxt = {i_mi_data_out, r_rlo};
        w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Registered outputs are decoded from the state being entered.
    unique case (w_state_nxt)
      S_PRECHK, S_POLL: begin
        w_cs_nxt    = 1'b1;
        w_rd_nxt    = 1'b1;
        w_maddr_nxt = REG_STAT;
      end
      S_LOAD: begin
        w_cs_nxt    = 1'b1;
        w_wr_nxt    = 1'b1;
        w_maddr_nxt = 4'(w_k_nxt) + 4'd1;
        case (w_k_nxt)
          3'd0:    w_din_nxt = r_addr[7:0];
          3'd1:    w_din_nxt = r_addr[15:8];
          3'd2:    w_din_nxt = {1'b0, r_addr[22:16]};
          3'd3:    w_din_nxt = r_wdata[7:0];
          default: w_din_nxt = r_wdata[15:8];
        endcase
      end
      S_CMD: begin
        w_cs_nxt    = 1'b1;
        w_wr_nxt    = 1'b1;
        w_maddr_nxt = r_we ? REG_START_WR : REG_START_RD;
      end
      S_GAP: w_cs_nxt = 1'b1;
      S_RDLO: begin
        w_cs_nxt    = 1'b1;
        w_rd_nxt    = 1'b1;
        w_maddr_nxt = REG_RDLO;
      end
      S_RDHI: begin
        w_cs_nxt    = 1'b1;
        w_rd_nxt    = 1'b1;
        w_maddr_nxt = REG_RDHI;
      end
      S_DONE: begin
        w_ack0_nxt = ~w_grant_nxt;
        w_ack1_nxt = w_grant_nxt;
      end
      default: ;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_k     <= 3'd0;
      r_cnt   <= '0;
      r_grant <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rlo   <= 8'd0;
      r_rdata <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_cs    <= 1'b0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_maddr <= 4'd0;
      r_din   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_rlo   <= w_rlo_nxt;
      r_rdata <= w_rdata_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
      r_cs    <= w_cs_nxt;
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_maddr <= w_maddr_nxt;
      r_din   <= w_din_nxt;
    end
  end

  assign o_ack0       = r_ack0;
  assign o_ack1       = r_ack1;
  assign o_rdata      = r_rdata;
  assign o_err        = r_err;
  assign o_busy       = r_busy;
  assign o_mi_cs      = r_cs;
  assign o_mi_write   = r_wr;
  assign o_mi_read    = r_rd;
  assign o_mi_address = r_maddr;
  assign o_mi_data_in = r_din;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter against a behavioural register-mapped memory controller.
module tb_mem_port_arbiter;

  localparam int unsigned TO        = 16;
  localparam int unsigned PWR_WAIT  = 15000;
  localparam int unsigned STAT_DLY  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [22:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, err, busy, cs, wr, rd;
  logic [15:0] rdata;
  logic [3:0]  maddr;
  logic [7:0]  din, mdo;

  always #5 clk = ~clk;

  mem_port_arbiter #(.POLL_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0), .o_ack0(ack0),
    .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1), .o_ack1(ack1),
    .o_rdata(rdata), .o_err(err), .o_busy(busy),
    .o_mi_cs(cs), .o_mi_write(wr), .o_mi_read(rd), .o_mi_address(maddr),
    .o_mi_data_in(din), .i_mi_data_out(mdo)
  );

  // Controller model: 16-entry memory indexed by addr[3:0], tag keeps the full address.
  logic [22:0] m_a = '0;
  logic [15:0] m_wd = '0, m_rd = '0;
  logic [15:0] mem [16];
  logic [22:0] tag [16];
  logic [3:0]  m_busy = '0;
  logic        m_stuck = 1'b0;
  logic        hang = 1'b0;
  logic        do_preload = 1'b0;
  int          pwr_cnt = 0;
  logic        pwr_ok, status;

  assign pwr_ok = (pwr_cnt >= int'(PWR_WAIT));
  assign status = pwr_ok && (m_busy == 4'd0) && !m_stuck;

  always @(posedge clk) begin
    if (do_preload) begin
      mem[0] <= 16'hC0DE;
      tag[0] <= 23'h000010;
    end
    if (rst_n && !pwr_ok) pwr_cnt <= pwr_cnt + 1;
    if (m_busy != 4'd0) m_busy <= m_busy - 4'd1;
    m_stuck <= m_stuck && hang;
    if (cs && wr) begin
      case (maddr)
        4'd1: m_a[7:0]   <= din;
        4'd2: m_a[15:8]  <= din;
        4'd3: m_a[22:16] <= din[6:0];
        4'd4: m_wd[7:0]  <= din;
        4'd5: m_wd[15:8] <= din;
        4'd8: begin
          m_rd    <= mem[m_a[3:0]];
          m_busy  <= 4'(STAT_DLY);
          m_stuck <= hang;
        end
        4'd9: begin
          mem[m_a[3:0]] <= m_wd;
          tag[m_a[3:0]] <= m_a;
          m_busy  <= 4'(STAT_DLY);
          m_stuck <= hang;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mdo = 8'h00;
    if (cs && rd) begin
      case (maddr)
        4'd6:    mdo = m_rd[7:0];
        4'd7:    mdo = m_rd[15:8];
        4'd10:   mdo = {7'd0, status};
        default: mdo = 8'h00;
      endcase
    end
  end

  typedef struct packed {
    logic       rd;
    logic [3:0] a;
    logic [7:0] d;
  } acc_t;

  typedef struct packed {
    logic        who;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] polls;
  } ack_t;

  acc_t        acc_q[$];
  ack_t        ack_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_rdata = 16'h0000;
  logic [63:0] outs;

  assign outs = 64'({ack0, ack1, rdata, err, busy, cs, wr, rd, maddr, din});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic acc_t mk_acc(input logic r, input logic [3:0] a, input logic [7:0] d);
    acc_t x;
    x.rd = r;
    x.a  = a;
    x.d  = d;
    return x;
  endfunction

  // Pushes the full register sequence and ack a transaction must produce.
  task automatic expect_txn(input logic who, input logic we, input logic [22:0] a,
                            input logic [15:0] wd, input logic [15:0] rd_val, input logic tmo);
    ack_t k;
    acc_q.push_back(mk_acc(1'b0, 4'd1, a[7:0]));
    acc_q.push_back(mk_acc(1'b0, 4'd2, a[15:8]));
    acc_q.push_back(mk_acc(1'b0, 4'd3, {1'b0, a[22:16]}));
    if (we) begin
      acc_q.push_back(mk_acc(1'b0, 4'd4, wd[7:0]));
      acc_q.push_back(mk_acc(1'b0, 4'd5, wd[15:8]));
    end
    acc_q.push_back(mk_acc(1'b0, we ? 4'd9 : 4'd8, 8'h00));
    if (!we && !tmo) begin
      acc_q.push_back(mk_acc(1'b1, 4'd6, 8'h00));
      acc_q.push_back(mk_acc(1'b1, 4'd7, 8'h00));
      exp_rdata = rd_val;
    end
    k.who   = who;
    k.err   = tmo;
    k.rdata = exp_rdata;
    k.polls = tmo ? 16'(TO) : 16'(STAT_DLY);
    ack_q.push_back(k);
  endtask

  task automatic wait_ack(input logic who, input int limit);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    while (!got && n < limit) begin
      @(negedge clk);
      n++;
      got = who ? ack1 : ack0;
    end
    check(who ? "ack1_seen" : "ack0_seen", 64'(got), 64'd1);
  endtask

  task automatic wait_acks(input int want, input int limit);
    int n, acks;
    n    = 0;
    acks = 0;
    while (acks < want && n < limit) begin
      @(negedge clk);
      n++;
      if (ack0 || ack1) acks++;
    end
    check("ack_count", 64'(acks), 64'(want));
  endtask

  // Monitor: pops expectations whenever the DUT presents a register access or an ack.
  initial begin
    acc_t ea;
    ack_t ek;
    int   poll_cnt;
    poll_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (wr || (rd && maddr != 4'd10)) begin
          check("acc_expected", 64'(acc_q.size() != 0), 64'd1);
          if (acc_q.size() != 0) begin
            ea = acc_q.pop_front();
            check("access", 64'({rd, maddr, din}), 64'(ea));
          end
          if (wr) check("wr_after_pwr", 64'(pwr_ok), 64'd1);
          if (wr && (maddr == 4'd8 || maddr == 4'd9)) poll_cnt = 0;
        end
        if (rd && maddr == 4'd10) poll_cnt++;
        if (ack0 || ack1) begin
          check("one_ack", 64'(ack0 & ack1), 64'd0);
          check("ack_expected", 64'(ack_q.size() != 0), 64'd1);
          if (ack_q.size() != 0) begin
            ek = ack_q.pop_front();
            check("ack_who", 64'(ack1), 64'(ek.who));
            check("ack_err", 64'(err), 64'(ek.err));
            check("ack_rdata", 64'(rdata), 64'(ek.rdata));
            check("ack_polls", 64'(poll_cnt), 64'(ek.polls));
            check("ack_busy_cs", 64'({busy, cs}), 64'd2);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    do_preload = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", outs, 64'd0);
    do_preload = 1'b0;
    rst_n = 1'b1;

    // Power-up: status stays 0 for 15000 cycles, request at cycle 5.
    repeat (5) @(negedge clk);
    check("idle_outs", outs, 64'd0);
    expect_txn(1'b0, 1'b1, 23'h000123, 16'h5A5A, 16'h0000, 1'b0);
    req0 = 1'b1; we0 = 1'b1; addr0 = 23'h000123; wdata0 = 16'h5A5A;
    wait_ack(1'b0, 16000);
    req0 = 1'b0;
    check("pwr_mem", 64'(mem[3]), 64'h5A5A);

    // Basic write from requester 0.
    @(negedge clk);
    expect_txn(1'b0, 1'b1, 23'h4A1234, 16'hBEEF, 16'h0000, 1'b0);
    req0 = 1'b1; we0 = 1'b1; addr0 = 23'h4A1234; wdata0 = 16'hBEEF;
    wait_ack(1'b0, 100);
    req0 = 1'b0;
    check("wr_mem", 64'(mem[4]), 64'hBEEF);
    check("wr_tag", 64'(tag[4]), 64'h4A1234);

    // Basic read from requester 1 of preloaded data.
    @(negedge clk);
    expect_txn(1'b1, 1'b0, 23'h000010, 16'h0000, 16'hC0DE, 1'b0);
    req1 = 1'b1; we1 = 1'b0; addr1 = 23'h000010; wdata1 = 16'hFFFF;
    wait_ack(1'b1, 100);
    req1 = 1'b0;

    // Contention right after reset: 0,1,0,1 while both stay high.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset2_outs", outs, 64'd0);
    rst_n = 1'b1;
    exp_rdata = 16'h0000;
    @(negedge clk);
    expect_txn(1'b0, 1'b1, 23'h000201, 16'h1111, 16'h0000, 1'b0);
    expect_txn(1'b1, 1'b0, 23'h000010, 16'h0000, 16'hC0DE, 1'b0);
    expect_txn(1'b0, 1'b1, 23'h000201, 16'h1111, 16'h0000, 1'b0);
    expect_txn(1'b1, 1'b0, 23'h000010, 16'h0000, 16'hC0DE, 1'b0);
    req0 = 1'b1; we0 = 1'b1; addr0 = 23'h000201; wdata0 = 16'h1111;
    req1 = 1'b1; we1 = 1'b0; addr1 = 23'h000010; wdata1 = 16'h2222;
    wait_acks(4, 400);
    req0 = 1'b0;
    req1 = 1'b0;

    // Poll timeout on a read: err set, rdata untouched.
    @(negedge clk);
    hang = 1'b1;
    expect_txn(1'b0, 1'b0, 23'h000010, 16'h0000, 16'h0000, 1'b1);
    req0 = 1'b1; we0 = 1'b0; addr0 = 23'h000010;
    wait_ack(1'b0, 200);
    req0 = 1'b0;
    hang = 1'b0;

    // Service resumes normally after the timeout.
    @(negedge clk);
    expect_txn(1'b1, 1'b1, 23'h000302, 16'h7E57, 16'h0000, 1'b0);
    req1 = 1'b1; we1 = 1'b1; addr1 = 23'h000302; wdata1 = 16'h7E57;
    wait_ack(1'b1, 200);
    req1 = 1'b0;
    check("post_to_mem", 64'(mem[2]), 64'h7E57);

    // Reset during the third LOAD cycle aborts silently.
    @(negedge clk);
    acc_q.push_back(mk_acc(1'b0, 4'd1, 8'h03));
    acc_q.push_back(mk_acc(1'b0, 4'd2, 8'h04));
    acc_q.push_back(mk_acc(1'b0, 4'd3, 8'h00));
    req0 = 1'b1; we0 = 1'b1; addr0 = 23'h000403; wdata0 = 16'h1234;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (wr && maddr == 4'd3) found = 1'b1;
    end
    check("saw_load3", 64'(found), 64'd1);
    #2;
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    check("midload_reset_outs", outs, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = 16'h0000;
    @(negedge clk);
    expect_txn(1'b0, 1'b1, 23'h000504, 16'hABCD, 16'h0000, 1'b0);
    expect_txn(1'b1, 1'b0, 23'h000010, 16'h0000, 16'hC0DE, 1'b0);
    req0 = 1'b1; we0 = 1'b1; addr0 = 23'h000504; wdata0 = 16'hABCD;
    req1 = 1'b1; we1 = 1'b0; addr1 = 23'h000010;
    wait_acks(2, 200);
    req0 = 1'b0;
    req1 = 1'b0;

    repeat (5) @(negedge clk);
    check("acc_q_empty", 64'(acc_q.size()), 64'd0);
    check("ack_q_empty", 64'(ack_q.size()), 64'd0);
    check("final_busy", 64'(busy), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
